demux_32bits_6: RTL and testbench

DEMUX_32BITS_6 -- requirements
Module: demux_32bits_6

---
 rtl/demux_32bits_6.sv | 76 +++++++
 tb/tb_demux_32bits_6.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/demux_32bits_6.sv
// Six-way registered demultiplexer with one-word slots per destination,
// valid/ready handshakes on both sides and a saturating drop counter.
module demux_32bits_6 #(
   parameter int LARGURA = 32
) (
   input  logic               clock,
   input  logic               reset,
   input  logic [LARGURA-1:0] entrada,
   input  logic [3:0]         seletor,
   input  logic               entrada_valida,
   output logic               entrada_pronta,
   output logic [LARGURA-1:0] saida1,
   output logic [LARGURA-1:0] saida2,
   output logic [LARGURA-1:0] saida3,
   output logic [LARGURA-1:0] saida4,
   output logic [LARGURA-1:0] saida5,
   output logic [LARGURA-1:0] saida6,
   output logic [5:0]         saida_valida,
   input  logic [5:0]         saida_pronta,
   output logic               erro,
   output logic [7:0]         descartes
);

   logic [LARGURA-1:0] dado [6];
   logic [5:0]         alvo;
   logic [5:0]         dreno;
   logic [5:0]         carga;
   logic               legal;
   logic               descarte;

   // One-hot destination; all-zero means an illegal code
   always_comb begin
      alvo = '0;
      unique case (seletor)
         4'b0000: alvo = 6'b000001;
         4'b0001: alvo = 6'b000010;
         4'b0010: alvo = 6'b000100;
         4'b0110: alvo = 6'b001000;
         4'b0111: alvo = 6'b010000;
         4'b1100: alvo = 6'b100000;
         default: alvo = 6'b000000;
      endcase
   end

   assign legal    = |alvo;
   assign dreno    = saida_valida & saida_pronta;
   assign entrada_pronta =
      !legal || (|(alvo & (~saida_valida | dreno)));
   assign carga    = {6{entrada_valida & entrada_pronta}} & alvo;
   assign descarte = entrada_valida && !legal;

   always_ff @(posedge clock) begin
      if (reset) begin
         saida_valida <= '0;
         erro         <= 1'b0;
         descartes    <= '0;
         for (int k = 0; k < 6; k++) dado[k] <= '0;
      end else begin
         // A load wins over a drain of the same slot
         saida_valida <= (saida_valida & ~dreno) | carga;
         erro         <= descarte;
         if (descarte && descartes != 8'hFF)
            descartes <= descartes + 8'd1;
         for (int k = 0; k < 6; k++)
            if (carga[k]) dado[k] <= entrada;
      end
   end

   assign saida1 = dado[0];
   assign saida2 = dado[1];
   assign saida3 = dado[2];
   assign saida4 = dado[3];
   assign saida5 = dado[4];
   assign saida6 = dado[5];

endmodule

// File: tb/tb_demux_32bits_6.sv
// Scoreboard bench for demux_32bits_6: per-destination queues of expected
// words, drained by a monitor, plus a drop-counter model.
module tb_demux_32bits_6;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic [31:0] entrada = '0;
   logic [3:0]  seletor = '0;
   logic        entrada_valida = 1'b0;
   logic        entrada_pronta;
   logic [31:0] saida1, saida2, saida3, saida4, saida5, saida6;
   logic [5:0]  saida_valida;
   logic [5:0]  saida_pronta = '0;
   logic        erro;
   logic [7:0]  descartes;

   demux_32bits_6 #(.LARGURA(32)) dut (
      .clock(clock),
      .reset(reset),
      .entrada(entrada),
      .seletor(seletor),
      .entrada_valida(entrada_valida),
      .entrada_pronta(entrada_pronta),
      .saida1(saida1),
      .saida2(saida2),
      .saida3(saida3),
      .saida4(saida4),
      .saida5(saida5),
      .saida6(saida6),
      .saida_valida(saida_valida),
      .saida_pronta(saida_pronta),
      .erro(erro),
      .descartes(descartes)
   );

   always #5 clock = ~clock;

   int          checks = 0;
   int          errors = 0;
   logic        armed = 1'b0;
   logic [31:0] q [6][$];
   logic        exp_erro = 1'b0;
   int          exp_desc = 0;
   logic [31:0] sa [6];
   logic [3:0]  codes [6] = '{4'h0, 4'h1, 4'h2, 4'h6, 4'h7, 4'hC};

   assign sa[0] = saida1;
   assign sa[1] = saida2;
   assign sa[2] = saida3;
   assign sa[3] = saida4;
   assign sa[4] = saida5;
   assign sa[5] = saida6;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp,
                  $time);
      end
   endtask

   function automatic int dest(input logic [3:0] s);
      for (int i = 0; i < 6; i++)
         if (codes[i] == s) return i;
      return -1;
   endfunction

   // Monitor: occupancy, held data, drains, erro and descartes
   always @(negedge clock) begin
      if (armed) begin
         for (int k = 0; k < 6; k++) begin
            chk($sformatf("valid%0d", k + 1), 32'(saida_valida[k]),
                32'(q[k].size() != 0));
            if (q[k].size() != 0)
               chk($sformatf("saida%0d", k + 1), sa[k], q[k][0]);
            if (saida_valida[k] && saida_pronta[k]) begin
               if (q[k].size() != 0) void'(q[k].pop_front());
               else chk($sformatf("drain_empty%0d", k + 1), 32'd1, 32'd0);
            end
         end
         chk("erro", 32'(erro), 32'(exp_erro));
         chk("descartes", 32'(descartes), 32'(exp_desc));
      end
   end

   // Reference model step, run after the monitor has retired drains
   task automatic model_step();
      int  d;
      logic rdy;
      d   = dest(seletor);
      rdy = (d < 0) || (q[d].size() == 0);
      chk("entrada_pronta", 32'(entrada_pronta), 32'(rdy));
      exp_erro = 1'b0;
      if (reset) begin
         for (int k = 0; k < 6; k++) q[k].delete();
         exp_desc = 0;
      end else if (entrada_valida && rdy) begin
         if (d >= 0) q[d].push_back(entrada);
         else begin
            exp_erro = 1'b1;
            if (exp_desc < 255) exp_desc++;
         end
      end
   endtask

   task automatic step(input logic v, input logic [3:0] s,
                       input logic [31:0] dt, input logic [5:0] p,
                       input logic r);
      @(posedge clock);
      #1;
      entrada_valida = v;
      seletor        = s;
      entrada        = dt;
      saida_pronta   = p;
      reset          = r;
      @(negedge clock);
      #1;
      model_step();
   endtask

   task automatic idle();
      step(1'b0, 4'h0, 32'h0, 6'h00, 1'b0);
   endtask

   initial begin
      logic [31:0] w [6];
      @(posedge clock);
      #1;
      armed = 1'b1;
      step(1'b0, 4'h0, 32'h0, 6'h00, 1'b1);
      idle();
      for (int k = 0; k < 6; k++)
         chk($sformatf("rst_saida%0d", k + 1), sa[k], 32'h0);

      step(1'b1, 4'b0110, 32'hDEADBEEF, 6'h00, 1'b0);
      idle();
      chk("one_word_valid", 32'(saida_valida), 32'h08);
      chk("one_word_data", saida4, 32'hDEADBEEF);
      chk("one_word_other", saida1 | saida2 | saida3 | saida5 | saida6,
          32'h0);

      step(1'b1, 4'b0000, 32'h11111111, 6'h00, 1'b0);
      step(1'b1, 4'b0000, 32'h22222222, 6'h00, 1'b0);
      chk("full_blocked", 32'(entrada_pronta), 32'd0);
      step(1'b1, 4'b0000, 32'h22222222, 6'h01, 1'b0);
      idle();
      chk("pass_through", saida1, 32'h22222222);

      step(1'b0, 4'h0, 32'h0, 6'h3F, 1'b0);
      for (int k = 0; k < 6; k++) w[k] = $urandom;
      for (int k = 0; k < 6; k++) step(1'b1, codes[k], w[k], 6'h00, 1'b0);
      idle();
      chk("all_full", 32'(saida_valida), 32'h3F);
      for (int k = 0; k < 6; k++)
         chk($sformatf("all_data%0d", k + 1), sa[k], w[k]);

      step(1'b1, 4'b0011, 32'hBAD0BAD0, 6'h00, 1'b0);
      idle();
      chk("first_drop", 32'(descartes), 32'd1);
      for (int i = 0; i < 300; i++)
         step(1'b1, 4'b0011, $urandom, 6'h00, 1'b0);
      idle();
      chk("drop_sat", 32'(descartes), 32'd255);
      for (int i = 0; i < 10; i++)
         step(1'b0, 4'b0011, $urandom, 6'h00, 1'b0);
      chk("idle_no_drop", 32'(descartes), 32'd255);

      step(1'b0, 4'h0, 32'h0, 6'h3F, 1'b0);
      step(1'b1, 4'b0001, 32'hA5A5A5A5, 6'h00, 1'b0);
      step(1'b1, 4'b0111, 32'h5A5A5A5A, 6'h00, 1'b0);
      step(1'b0, 4'h0, 32'h0, 6'b010010, 1'b1);
      idle();
      chk("rst_mid_valid", 32'(saida_valida), 32'h0);
      chk("rst_mid_desc", 32'(descartes), 32'h0);

      for (int i = 0; i < 3000; i++) begin
         logic [3:0] s;
         if ($urandom_range(0, 3) != 0) s = codes[$urandom_range(0, 5)];
         else s = 4'($urandom_range(0, 15));
         step($urandom_range(0, 3) != 0, s, $urandom,
              6'($urandom), $urandom_range(0, 199) == 0);
      end
      idle();
      armed = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", checks,
               errors);
      $finish;
   end

endmodule
